oam_dma_ctrl: RTL and testbench

//  CPU-side OAM DMA engine, triggered by a CPU write to $4014.

---
 rtl/nes_bus_pkg.sv | 26 ++
 rtl/oam_dma_ctrl.sv | 131 +++++++++++++
 tb/tb_oam_dma_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared NES CPU/PPU bus constants and the OAM DMA state encoding.
// Imported by oam_dma_ctrl.
package nes_bus_pkg;

    // PPU register selects ($2000..$2007)
    localparam logic [2:0] PPU_CTRL    = 3'd0;
    localparam logic [2:0] PPU_MASK    = 3'd1;
    localparam logic [2:0] PPU_STATUS  = 3'd2;
    localparam logic [2:0] PPU_OAMADDR = 3'd3;
    localparam logic [2:0] PPU_OAMDATA = 3'd4;
    localparam logic [2:0] PPU_SCROLL  = 3'd5;
    localparam logic [2:0] PPU_ADDR    = 3'd6;
    localparam logic [2:0] PPU_DATA    = 3'd7;

    // CPU register that starts a sprite DMA
    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: on a $4014 write, halt the CPU and copy one page
// into PPU OAMDATA. Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN.
module oam_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_ADDR,
    parameter logic [2:0]  OAM_DATA_SEL = PPU_OAMDATA,
    parameter int          XFER_LEN     = 256
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        cpu_ce_in,
    input  logic        reg_wr_in,
    input  logic [15:0] reg_addr_in,
    input  logic [7:0]  reg_d_in,
    output logic        cpu_halt_out,
    output logic        mem_rd_out,
    output logic [15:0] mem_addr_out,
    input  logic [7:0]  mem_d_in,
    output logic [2:0]  ppu_sel_out,
    output logic        ppu_ncs_out,
    output logic        ppu_r_nw_out,
    output logic [7:0]  ppu_d_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q,  data_d;
    logic       parity_q, parity_d;
    logic       done_q,  done_d;
    logic       trig;
    logic       in_read;
    logic       in_write;

    assign trig = reg_wr_in && (reg_addr_in == DMA_REG_ADDR);

`ifndef OAM_DMA_ALIGN_EN
    // Parity is kept for timing visibility even when ALIGN is absent.
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

    // State, counters and captured byte; async reset aborts any transfer.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= DMA_IDLE;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    // Next-state: only IDLE reacts mid-cycle; all others step on cpu_ce_in.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        data_d   = data_q;
        done_d   = 1'b0;
        parity_d = parity_q ^ cpu_ce_in;
        unique case (state_q)
            DMA_IDLE: begin
                if (trig) begin
                    page_d  = reg_d_in;
                    index_d = 8'h00;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT: begin
                if (cpu_ce_in) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = parity_q ? DMA_ALIGN : DMA_READ;
`else
                    state_d = DMA_READ;
`endif
                end
            end
            DMA_ALIGN: begin
                if (cpu_ce_in) begin
                    state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                if (cpu_ce_in) begin
                    data_d  = mem_d_in;
                    state_d = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                if (cpu_ce_in) begin
                    index_d = index_q + 8'd1;
                    if (index_q == LAST_IDX) begin
                        state_d = DMA_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DMA_READ;
                    end
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    assign in_read  = (state_q == DMA_READ);
    assign in_write = (state_q == DMA_WRITE);

    assign busy_out     = (state_q != DMA_IDLE);
    assign cpu_halt_out = busy_out;
    assign mem_rd_out   = in_read;
    assign mem_addr_out = in_read ? {page_q, index_q} : 16'h0000;
    assign ppu_ncs_out  = ~in_write;
    assign ppu_r_nw_out = ~in_write;
    assign ppu_sel_out  = in_write ? OAM_DATA_SEL : 3'd0;
    assign ppu_d_out    = data_q;
    assign done_out     = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: scenario table, corner
// sequences and random transfers against a transaction-level model.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_in;
    logic        cpu_ce_in;
    logic        reg_wr_in;
    logic [15:0] reg_addr_in;
    logic [7:0]  reg_d_in;
    logic        cpu_halt_out;
    logic        mem_rd_out;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_d_in;
    logic [2:0]  ppu_sel_out;
    logic        ppu_ncs_out;
    logic        ppu_r_nw_out;
    logic [7:0]  ppu_d_out;
    logic        busy_out;
    logic        done_out;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .cpu_ce_in    (cpu_ce_in),
        .reg_wr_in    (reg_wr_in),
        .reg_addr_in  (reg_addr_in),
        .reg_d_in     (reg_d_in),
        .cpu_halt_out (cpu_halt_out),
        .mem_rd_out   (mem_rd_out),
        .mem_addr_out (mem_addr_out),
        .mem_d_in     (mem_d_in),
        .ppu_sel_out  (ppu_sel_out),
        .ppu_ncs_out  (ppu_ncs_out),
        .ppu_r_nw_out (ppu_r_nw_out),
        .ppu_d_out    (ppu_d_out),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    always #5 clk = ~clk;

    // CPU memory image: a fixed scramble of the address
    function automatic logic [7:0] img(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0] * 8'd7;
        return lo ^ a[15:8] ^ 8'h5A;
    endfunction

    assign mem_d_in = img(mem_addr_out);

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // CPU cycle counter: cycles completed since reset
    int unsigned ce_total;
    always @(posedge clk) begin
        if (rst_in) ce_total <= 0;
        else if (cpu_ce_in) ce_total <= ce_total + 1;
    end

    // CPU cycle strobes, 2 or 3 clocks apart
    initial begin
        cpu_ce_in = 1'b0;
        forever begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1 cpu_ce_in = 1'b1;
            @(posedge clk);
            #1 cpu_ce_in = 1'b0;
        end
    end

    // Transaction monitor
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    int busy_ce, idle_ce, done_cnt;
    logic prev_ncs;

    initial begin
        prev_ncs = 1'b1;
        busy_ce  = 0;
        idle_ce  = 0;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_in) begin
                prev_ncs = 1'b1;
            end else begin
                if (done_out) done_cnt++;
                if (cpu_ce_in && busy_out) begin
                    busy_ce++;
                    if (mem_rd_out) rd_q.push_back(mem_addr_out);
                    else if (ppu_ncs_out) idle_ce++;
                end
                if (prev_ncs && !ppu_ncs_out) begin
                    wr_q.push_back(ppu_d_out);
                    check("wr_sel", ppu_sel_out, 3'd4);
                    check("wr_rnw", ppu_r_nw_out, 1'b0);
                end
                prev_ncs = ppu_ncs_out;
            end
        end
    end

    task automatic clear_mon();
        rd_q.delete();
        wr_q.delete();
        busy_ce  = 0;
        idle_ce  = 0;
        done_cnt = 0;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        reg_wr_in   = 1'b1;
        reg_addr_in = a;
        reg_d_in    = d;
        @(negedge clk);
        reg_wr_in   = 1'b0;
        reg_addr_in = 16'($urandom);
        reg_d_in    = 8'($urandom);
    endtask

    // Write $4014 so the HALT cycle lands on the wanted parity.
    // The model's ALIGN expectation follows from that cycle's parity.
    task automatic trigger(input logic [7:0] page, input bit coinc,
                           input bit want_odd, output bit exp_align);
        int tries;
        int unsigned halt_idx;
        tries = 0;
        do begin
            @(negedge clk);
            tries++;
            halt_idx = ce_total + (cpu_ce_in ? 1 : 0);
        end while (!(cpu_ce_in == coinc && halt_idx[0] == want_odd)
                   && tries < 200);
        exp_align = ALIGN_EN && halt_idx[0];
        reg_write(16'h4014, page);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_out !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, done_out, 1'b1);
        check({name, "_busy_at_done"}, busy_out, 1'b0);
        check({name, "_halt_at_done"}, cpu_halt_out, 1'b0);
        check({name, "_ncs_at_done"}, ppu_ncs_out, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic verify(input string name, input logic [7:0] page,
                          input bit al);
        logic [15:0] ea;
        check({name, "_rd_count"}, rd_q.size(), 256);
        check({name, "_wr_count"}, wr_q.size(), 256);
        for (int i = 0; i < 256; i++) begin
            ea = {page, 8'(i)};
            if (i < rd_q.size()) check({name, "_rd_addr"}, rd_q[i], ea);
            if (i < wr_q.size()) check({name, "_wr_data"}, wr_q[i], img(ea));
        end
        check({name, "_cycles"}, busy_ce, 513 + al);
        check({name, "_pre_cycles"}, idle_ce, 1 + al);
        check({name, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic run_xfer(input string name, input logic [7:0] page,
                            input bit coinc, input bit odd);
        bit al;
        clear_mon();
        trigger(page, coinc, odd, al);
        wait_done(name);
        verify(name, page, al);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_halt"}, cpu_halt_out, 1'b0);
        check({name, "_busy"}, busy_out, 1'b0);
        check({name, "_ncs"}, ppu_ncs_out, 1'b1);
        check({name, "_rnw"}, ppu_r_nw_out, 1'b1);
        check({name, "_rd"}, mem_rd_out, 1'b0);
        check({name, "_addr"}, mem_addr_out, 16'h0000);
        check({name, "_sel"}, ppu_sel_out, 3'd0);
        check({name, "_d"}, ppu_d_out, 8'h00);
        check({name, "_done"}, done_out, 1'b0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          coinc;
        bit          odd;
        bit          exp_busy;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n, busy_seen;
        bit al;

        tbl[0] = '{16'h4014, 8'h02, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{16'h4014, 8'h02, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{16'h4014, 8'h02, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{16'h4015, 8'h02, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16'h2004, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'h4014, 8'h20, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{16'h4014, 8'hFF, 1'b1, 1'b1, 1'b1};

        rst_in      = 1'b1;
        reg_wr_in   = 1'b0;
        reg_addr_in = 16'h0000;
        reg_d_in    = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_in = 1'b0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            if (tbl[k].exp_busy) begin
                run_xfer($sformatf("tbl%0d", k), tbl[k].data,
                         tbl[k].coinc, tbl[k].odd);
            end else begin
                clear_mon();
                @(negedge clk);
                reg_write(tbl[k].addr, tbl[k].data);
                busy_seen = 0;
                repeat (30) begin
                    if (busy_out !== 1'b0 || cpu_halt_out !== 1'b0) busy_seen++;
                    @(negedge clk);
                end
                check($sformatf("tbl%0d_nobusy", k), busy_seen, 0);
                check($sformatf("tbl%0d_nord", k), rd_q.size(), 0);
            end
        end

        // Retrigger with $07 while copying byte 100 of page $03
        clear_mon();
        trigger(8'h03, 1'b1, 1'b0, al);
        n = 0;
        while (rd_q.size() < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("retrig_reach", rd_q.size(), 100);
        reg_write(16'h4014, 8'h07);
        wait_done("retrig");
        verify("retrig", 8'h03, al);

        // Reset at byte 40, then a clean $05 transfer
        clear_mon();
        trigger(8'h0A, 1'b0, 1'b0, al);
        n = 0;
        while (rd_q.size() < 40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", rd_q.size(), 40);
        rst_in = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst_in = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", busy_out, 1'b0);
        run_xfer("after_rst", 8'h05, 1'b1, 1'b0);

        // Random transfers
        for (int r = 0; r < 4; r++) begin
            run_xfer($sformatf("rnd%0d", r), 8'($urandom),
                     1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
